// File: rtl/i2c_master_seq_if.sv
// ---------------------------------------------------------------------------
// i2c_master_seq_if
//   Command/response handshake bundle between a host and i2c_master_seq.
//   Signal names are from the sequencer's point of view (i_ = into the
//   sequencer, o_ = out of it).
//
//   Command:  i_cmd_valid / o_cmd_ready, i_cmd[1:0] (0 START, 1 STOP,
//             2 WRITE, 3 READ), i_cmd_data[7:0], i_cmd_ack (0 = ACK on READ)
//   Response: o_rsp_valid / i_rsp_ready, o_rsp_data[7:0], o_rsp_nack,
//             o_rsp_err
//
//   Modports: master - used by the sequencer
//             slave  - used by the host driving commands
// ---------------------------------------------------------------------------
interface i2c_master_seq_if;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [1:0] i_cmd;
    logic [7:0] i_cmd_data;
    logic       i_cmd_ack;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_data;
    logic       o_rsp_nack;
    logic       o_rsp_err;

    modport master (
        input  i_cmd_valid, i_cmd, i_cmd_data, i_cmd_ack, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_nack, o_rsp_err
    );

    modport slave (
        output i_cmd_valid, i_cmd, i_cmd_data, i_cmd_ack, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_nack, o_rsp_err
    );
endinterface

// File: rtl/i2c_master_seq.sv
// ---------------------------------------------------------------------------
// i2c_master_seq
//   Sequences I2C bus primitives by handing each command to one of four
//   generators (0 START, 1 STOP, 2 WRITE, 3 READ), waiting for it to finish,
//   and returning a single response per command. The selected generator's
//   SDA/SCL drive is muxed onto the bus while it owns the transaction.
//
//   Ports:
//     i_clk, i_rst_n           clock, asynchronous active-low reset
//     host (master modport)    command / response handshake
//     o_gen_enable, o_gen_req  per-generator enable and start request
//     i_gen_ready, i_gen_done  per-generator request accept / completion
//     i_gen_sda, i_gen_scl     per-generator bus drive levels
//     o_wr_data, i_wr_nack     WRITE byte out, slave NACK back
//     o_rd_ack, i_rd_data      READ master ACK level out, byte back
//     o_sda_drive, o_scl_drive muxed bus drive (held when no owner)
//     o_busy                   high between a completed START and STOP
//
//   Optional feature: define I2C_SEQ_TIMEOUT_EN to add a watchdog that
//   aborts a transaction after TIMEOUT_CYCLES cycles in ISSUE/WAIT_DONE.
// ---------------------------------------------------------------------------
module i2c_master_seq #(
    parameter int NUM_GEN        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    i2c_master_seq_if.master   host,
    output logic [NUM_GEN-1:0] o_gen_enable,
    output logic [NUM_GEN-1:0] o_gen_req,
    input  logic [NUM_GEN-1:0] i_gen_ready,
    input  logic [NUM_GEN-1:0] i_gen_done,
    input  logic [NUM_GEN-1:0] i_gen_sda,
    input  logic [NUM_GEN-1:0] i_gen_scl,
    output logic [7:0]         o_wr_data,
    input  logic               i_wr_nack,
    output logic               o_rd_ack,
    input  logic [7:0]         i_rd_data,
    output logic               o_sda_drive,
    output logic               o_scl_drive,
    output logic               o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;
    localparam logic [NUM_GEN-1:0] GEN_ONE = {{(NUM_GEN-1){1'b0}}, 1'b1};

    state_t      state_q, state_d;
    logic        ready_q;
    logic [1:0]  owner_q;
    logic [7:0]  data_q;
    logic        ack_q;
    logic        busy_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_nack_q;
    logic        rsp_err_q;
    logic        sda_q, scl_q;

    logic               accept, legal, active, tmo_hit;
    logic [NUM_GEN-1:0] owner_oh;

    assign accept   = (state_q == IDLE) && ready_q && host.i_cmd_valid;
    assign legal    = (host.i_cmd == OP_START) ? !busy_q : busy_q;
    assign active   = (state_q == ISSUE) || (state_q == WAIT_DONE);
    assign owner_oh = GEN_ONE << owner_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);
    logic [16:0] tmo_cnt_q;

    // Cleared at accept, so the count starts at 0 on the first ISSUE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
        end else if (active) begin
            tmo_cnt_q <= tmo_cnt_q + 17'd1;
        end
    end

    assign tmo_hit = active && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        o_gen_enable = '0;
        o_gen_req    = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = legal ? ISSUE : RESP;
            end
            ISSUE: begin
                o_gen_enable = owner_oh;
                o_gen_req    = owner_oh;
                if (tmo_hit)                   state_d = RESP;
                else if (i_gen_ready[owner_q]) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                o_gen_enable = owner_oh;
                if (tmo_hit || i_gen_done[owner_q]) state_d = RESP;
            end
            RESP: begin
                if (host.i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            owner_q    <= 2'd0;
            data_q     <= 8'h00;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_nack_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            // Registered so ready stays low through reset and rises one
            // cycle after release, and is never high in the RESP exit cycle.
            ready_q <= (state_d == IDLE);

            if (accept) begin
                owner_q <= host.i_cmd;
                data_q  <= host.i_cmd_data;
                ack_q   <= host.i_cmd_ack;
                if (!legal) begin
                    rsp_err_q  <= 1'b1;
                    rsp_nack_q <= 1'b0;
                    rsp_data_q <= 8'h00;
                end
            end

            // Remember the owner's drive so the bus holds it once released.
            if (active) begin
                sda_q <= i_gen_sda[owner_q];
                scl_q <= i_gen_scl[owner_q];
            end

            if (tmo_hit) begin
                rsp_err_q  <= 1'b1;
                rsp_nack_q <= 1'b0;
                rsp_data_q <= 8'h00;
                busy_q     <= 1'b0;
                sda_q      <= 1'b1;
                scl_q      <= 1'b1;
            end else if ((state_q == WAIT_DONE) && i_gen_done[owner_q]) begin
                rsp_err_q  <= 1'b0;
                rsp_nack_q <= (owner_q == OP_WRITE) ? i_wr_nack : 1'b0;
                rsp_data_q <= (owner_q == OP_READ) ? i_rd_data : 8'h00;
                if (owner_q == OP_START) busy_q <= 1'b1;
                if (owner_q == OP_STOP)  busy_q <= 1'b0;
            end
        end
    end

    assign host.o_cmd_ready = ready_q;
    assign host.o_rsp_valid = (state_q == RESP);
    assign host.o_rsp_data  = rsp_data_q;
    assign host.o_rsp_nack  = rsp_nack_q;
    assign host.o_rsp_err   = rsp_err_q;

    assign o_wr_data   = data_q;
    assign o_rd_ack    = ack_q;
    assign o_busy      = busy_q;
    assign o_sda_drive = active ? i_gen_sda[owner_q] : sda_q;
    assign o_scl_drive = active ? i_gen_scl[owner_q] : scl_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_seq
//   Directed bench for i2c_master_seq: a table of command vectors with
//   hand-computed responses, plus hand-written reset, abort and (when
//   I2C_SEQ_TIMEOUT_EN is defined) watchdog sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_master_seq;
    localparam int TMO = 20;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    i2c_master_seq_if bus();

    logic [3:0] o_gen_enable, o_gen_req;
    logic [3:0] i_gen_ready, i_gen_done, i_gen_sda, i_gen_scl;
    logic [7:0] o_wr_data, i_rd_data;
    logic       i_wr_nack, o_rd_ack, o_sda_drive, o_scl_drive, o_busy;

    i2c_master_seq #(.NUM_GEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .host         (bus),
        .o_gen_enable (o_gen_enable),
        .o_gen_req    (o_gen_req),
        .i_gen_ready  (i_gen_ready),
        .i_gen_done   (i_gen_done),
        .i_gen_sda    (i_gen_sda),
        .i_gen_scl    (i_gen_scl),
        .o_wr_data    (o_wr_data),
        .i_wr_nack    (i_wr_nack),
        .o_rd_ack     (o_rd_ack),
        .i_rd_data    (i_rd_data),
        .o_sda_drive  (o_sda_drive),
        .o_scl_drive  (o_scl_drive),
        .o_busy       (o_busy)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       ack;
        int         rdy_cyc;   // cycle after accept in which ready is given
        int         done_cyc;  // cycle after accept in which done is given
        logic       wr_nack;
        logic [7:0] rd_data;
        int         rsp_wait;  // cycles i_rsp_ready is held low
        bit         tmo;       // generator never completes
        logic       exp_err;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        logic       exp_busy;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    logic held_sda = 1'b1;
    logic held_scl = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data, input logic ack,
                                input int rdy, input int done, input logic wn,
                                input logic [7:0] rd, input int rw, input bit tmo,
                                input logic err, input logic nack, input logic [7:0] erd,
                                input logic busy);
        vec_t v;
        v.op = op; v.data = data; v.ack = ack; v.rdy_cyc = rdy; v.done_cyc = done;
        v.wr_nack = wn; v.rd_data = rd; v.rsp_wait = rw; v.tmo = tmo;
        v.exp_err = err; v.exp_nack = nack; v.exp_rdata = erd; v.exp_busy = busy;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] oh;
        logic       legal;
        int         lat, k, t;
        bit         got, req_ok, en_ok, drv_ok, hold_ok;
        logic [7:0] r_data;
        logic       r_nack, r_err;
        oh    = 4'b0001 << v.op;
        legal = !v.exp_err || v.tmo;
        lat   = !legal ? 1 : (v.tmo ? TMO + 1 : v.done_cyc + 1);
        i_wr_nack = v.wr_nack;
        i_rd_data = v.rd_data;

        t = 0;
        while (!bus.o_cmd_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        check($sformatf("v%0d_cmd_ready", idx), 32'(bus.o_cmd_ready), 32'd1);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = v.op;
        bus.i_cmd_data  = v.data;
        bus.i_cmd_ack   = v.ack;
        @(negedge i_clk);
        bus.i_cmd_valid = 1'b0;

        got = 0; req_ok = 1; en_ok = 1; drv_ok = 1; k = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            if (bus.o_rsp_valid) begin
                got = 1;
                k   = c;
            end else begin
                if (o_gen_req !== ((c <= v.rdy_cyc) ? oh : 4'b0000)) req_ok = 0;
                if (o_gen_enable !== oh) en_ok = 0;
                i_gen_sda = 4'($urandom);
                i_gen_scl = 4'($urandom);
                #1;
                if (o_sda_drive !== i_gen_sda[v.op] || o_scl_drive !== i_gen_scl[v.op]) drv_ok = 0;
                held_sda = i_gen_sda[v.op];
                held_scl = i_gen_scl[v.op];
                i_gen_ready = (c == v.rdy_cyc) ? oh : 4'b0000;
                // Owner's done is also pulsed throughout ISSUE and other
                // generators pulse done while waiting: all must be ignored.
                i_gen_done  = (c == v.done_cyc) ? oh : ((c <= v.rdy_cyc) ? oh : ~oh);
                @(negedge i_clk);
            end
        end
        i_gen_ready = 4'b0000;
        i_gen_done  = 4'b0000;
        if (v.tmo) begin
            held_sda = 1'b1;
            held_scl = 1'b1;
        end

        check($sformatf("v%0d_latency", idx), 32'(k), 32'(lat));
        if (legal) begin
            check($sformatf("v%0d_req_window", idx), 32'(req_ok), 32'd1);
            check($sformatf("v%0d_enable", idx), 32'(en_ok), 32'd1);
            check($sformatf("v%0d_drive_pass", idx), 32'(drv_ok), 32'd1);
        end
        check($sformatf("v%0d_rsp_err", idx), 32'(bus.o_rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_rsp_nack", idx), 32'(bus.o_rsp_nack), 32'(v.exp_nack));
        check($sformatf("v%0d_rsp_data", idx), 32'(bus.o_rsp_data), 32'(v.exp_rdata));
        check($sformatf("v%0d_wr_data", idx), 32'(o_wr_data), 32'(v.data));
        check($sformatf("v%0d_rd_ack", idx), 32'(o_rd_ack), 32'(v.ack));
        check($sformatf("v%0d_resp_enable", idx), 32'(o_gen_enable), 32'd0);
        check($sformatf("v%0d_resp_sda", idx), 32'(o_sda_drive), 32'(held_sda));
        check($sformatf("v%0d_resp_scl", idx), 32'(o_scl_drive), 32'(held_scl));
        check($sformatf("v%0d_resp_cmd_ready", idx), 32'(bus.o_cmd_ready), 32'd0);

        r_data = bus.o_rsp_data; r_nack = bus.o_rsp_nack; r_err = bus.o_rsp_err;
        hold_ok = 1;
        for (int w = 0; w < v.rsp_wait; w++) begin
            @(negedge i_clk);
            if (!bus.o_rsp_valid || bus.o_cmd_ready || bus.o_rsp_data !== r_data ||
                bus.o_rsp_nack !== r_nack || bus.o_rsp_err !== r_err) hold_ok = 0;
        end
        if (v.rsp_wait > 0) check($sformatf("v%0d_rsp_hold", idx), 32'(hold_ok), 32'd1);

        bus.i_rsp_ready = 1'b1;
        @(negedge i_clk);
        bus.i_rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_drop", idx), 32'(bus.o_rsp_valid), 32'd0);
        check($sformatf("v%0d_ready_back", idx), 32'(bus.o_cmd_ready), 32'd1);
        check($sformatf("v%0d_busy", idx), 32'(o_busy), 32'(v.exp_busy));
    endtask

    vec_t vecs[13];

    initial begin
        //          op    data   ack rdy done wn  rd     rw tmo err nack erd   busy
        vecs[0]  = mk(2'd0, 8'h00, 0, 2, 10, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
        vecs[1]  = mk(2'd2, 8'hA5, 0, 1, 4,  1, 8'h00, 0, 0, 0, 1, 8'h00, 1);
        vecs[2]  = mk(2'd3, 8'h00, 1, 3, 6,  0, 8'h3C, 5, 0, 0, 0, 8'h3C, 1);
        vecs[3]  = mk(2'd2, 8'h5A, 0, 1, 2,  0, 8'h99, 0, 0, 0, 0, 8'h00, 1);
        vecs[4]  = mk(2'd3, 8'h11, 0, 2, 3,  1, 8'hC3, 0, 0, 0, 0, 8'hC3, 1);
        vecs[5]  = mk(2'd0, 8'h00, 0, 1, 2,  0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        vecs[6]  = mk(2'd1, 8'h00, 0, 1, 3,  0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        vecs[7]  = mk(2'd2, 8'h42, 0, 1, 2,  1, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        vecs[8]  = mk(2'd1, 8'h00, 0, 1, 2,  0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        vecs[9]  = mk(2'd3, 8'h00, 1, 1, 2,  0, 8'hAA, 0, 0, 1, 0, 8'h00, 0);
        vecs[10] = mk(2'd0, 8'h00, 0, 1, 2,  0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
        vecs[11] = mk(2'd1, 8'h00, 0, 4, 5,  0, 8'h00, 2, 0, 0, 0, 8'h00, 0);
        vecs[12] = mk(2'd0, 8'h00, 0, 1, 3,  0, 8'h00, 0, 0, 0, 0, 8'h00, 1);

        bus.i_cmd_valid = 1'b0; bus.i_cmd = 2'd0; bus.i_cmd_data = 8'h00;
        bus.i_cmd_ack = 1'b0; bus.i_rsp_ready = 1'b1;
        i_gen_ready = 4'hF; i_gen_done = 4'hF; i_gen_sda = 4'h0; i_gen_scl = 4'h0;
        i_wr_nack = 1'b1; i_rd_data = 8'hFF;

        // Reset state with generator inputs active.
        repeat (3) @(negedge i_clk);
        check("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_rsp_fields", 32'({bus.o_rsp_data, bus.o_rsp_nack, bus.o_rsp_err}), 32'd0);
        check("rst_gen", 32'({o_gen_enable, o_gen_req}), 32'd0);
        check("rst_drive", 32'({o_sda_drive, o_scl_drive}), 32'd3);
        check("rst_busy", 32'(o_busy), 32'd0);

        bus.i_rsp_ready = 1'b0;
        i_gen_ready = 4'h0; i_gen_done = 4'h0;
        i_rst_n = 1'b1;
        #1;
        check("release_ready_low", 32'(bus.o_cmd_ready), 32'd0);
        @(negedge i_clk);
        check("release_ready_rise", 32'(bus.o_cmd_ready), 32'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Abort: reset during a stalled WRITE releases the bus, no response.
        bus.i_cmd_valid = 1'b1; bus.i_cmd = 2'd2; bus.i_cmd_data = 8'h77; bus.i_cmd_ack = 1'b0;
        @(negedge i_clk);
        bus.i_cmd_valid = 1'b0;
        i_gen_sda = 4'h0; i_gen_scl = 4'h0;
        #1;
        check("abort_pre_enable", 32'(o_gen_enable), 32'h4);
        check("abort_pre_drive", 32'({o_sda_drive, o_scl_drive}), 32'd0);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("abort_drive", 32'({o_sda_drive, o_scl_drive}), 32'd3);
        check("abort_gen", 32'({o_gen_enable, o_gen_req}), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        held_sda = 1'b1;
        held_scl = 1'b1;
        @(negedge i_clk);
        check("abort_ready_back", 32'(bus.o_cmd_ready), 32'd1);
        check("abort_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
        run_vec(mk(2'd0, 8'h00, 0, 2, 4, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1), 13);

`ifdef I2C_SEQ_TIMEOUT_EN
        // WRITE whose generator never completes: watchdog aborts.
        run_vec(mk(2'd2, 8'h3E, 0, 1, 0, 1, 8'h55, 0, 1, 1, 0, 8'h00, 0), 14);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, want finish");
        $fatal(1);
    end
endmodule
